// File: rtl/weight_pingpong_skew_buffer_pkg.sv
// ============================================================================
//  Module  : weight_pingpong_skew_buffer_pkg
//  Purpose : Shared configuration defaults, drain FSM state encoding and a
//            counter-width helper for the ping-pong weight skew buffer.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef DATASIZE
`define DATASIZE 8
`endif
`default_nettype none

package weight_pingpong_skew_buffer_pkg;

    // Drain FSM state encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_DRAIN = c_ST_DRAIN,
        ST_FLUSH = c_ST_FLUSH
    } drain_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/weight_pingpong_skew_buffer_if.sv
// ============================================================================
//  Module  : weight_pingpong_skew_buffer_if
//  Purpose : Loader / drain / output bundle of the ping-pong weight buffer.
//  Signals : load_valid/load_ready/load_data  row load handshake
//            drain_start/drain_busy           drain request and status
//            out_valid/out_weight/tile_done   skewed column outputs
//            banks_full                       per-bank full flags
//  Modports: master = loader/array side, slave = buffer
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface weight_pingpong_skew_buffer_if #(
    parameter int ARRAY_W = `ARRAYWIDTH,
    parameter int DATA_W  = `DATASIZE
);
    logic                      load_valid;
    logic                      load_ready;
    logic [ARRAY_W*DATA_W-1:0] load_data;
    logic                      drain_start;
    logic                      drain_busy;
    logic [ARRAY_W-1:0]        out_valid;
    logic [ARRAY_W*DATA_W-1:0] out_weight;
    logic                      tile_done;
    logic [1:0]                banks_full;

    modport master (
        output load_valid, load_data, drain_start,
        input  load_ready, drain_busy, out_valid, out_weight, tile_done, banks_full
    );

    modport slave (
        input  load_valid, load_data, drain_start,
        output load_ready, drain_busy, out_valid, out_weight, tile_done, banks_full
    );
endinterface

`default_nettype wire

// File: rtl/weight_pingpong_skew_buffer_skew_line.sv
// ============================================================================
//  Module  : weight_skew_line
//  Purpose : STAGES-deep delay line for one column's weight and valid.
//            STAGES=0 is a plain pass-through. Only valid bits are reset.
//  Ports   : clk, rst (async, active-high)
//            data_i/valid_i  column input
//            data_o/valid_o  delayed column output
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module weight_skew_line #(
    parameter int DATA_W = 8,
    parameter int STAGES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    generate
        if (STAGES == 0) begin : g_pass
            assign data_o  = data_i;
            assign valid_o = valid_i;
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = &{1'b0, clk, rst};
        end else begin : g_pipe
            logic [DATA_W-1:0] data_q [STAGES];
            logic [STAGES-1:0] valid_q;

            always_ff @(posedge clk) begin
                data_q[0] <= data_i;
                for (int k = 1; k < STAGES; k++) begin
                    data_q[k] <= data_q[k-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= '0;
                end else begin
                    valid_q[0] <= valid_i;
                    for (int k = 1; k < STAGES; k++) begin
                        valid_q[k] <= valid_q[k-1];
                    end
                end
            end

            assign data_o  = data_q[STAGES-1];
            assign valid_o = valid_q[STAGES-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/weight_pingpong_skew_buffer.sv
// ============================================================================
//  Module  : weight_pingpong_skew_buffer
//  Purpose : Double-banked weight tile buffer. The loader fills one bank a row
//            per handshake while the other bank drains one row per cycle into
//            per-column delay lines (column i delayed i cycles when SKEW_EN).
//  Ports   : clk            clock, rising edge
//            rst            asynchronous reset, active-high
//            buf_if.slave   load handshake, drain control, skewed outputs,
//                           per-bank full flags
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module weight_pingpong_skew_buffer
    import weight_pingpong_skew_buffer_pkg::*;
#(
    parameter int ARRAY_W = `ARRAYWIDTH,
    parameter int DATA_W  = `DATASIZE,
    parameter int DEPTH   = 8,
    parameter bit SKEW_EN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    weight_pingpong_skew_buffer_if.slave  buf_if
);

    localparam int ROW_W  = ARRAY_W * DATA_W;
    localparam int ROW_CW = cnt_width(DEPTH);
    localparam int FL_CW  = cnt_width(ARRAY_W - 1);
    localparam int ADDR_W = $clog2(2 * DEPTH);

    localparam bit                c_USE_FLUSH  = SKEW_EN && (ARRAY_W > 1);
    localparam logic [ROW_CW-1:0] c_ROW_LAST   = ROW_CW'(DEPTH - 1);
    localparam logic [ROW_CW-1:0] c_ROW_PENULT = ROW_CW'(DEPTH - 2);
    localparam logic [FL_CW-1:0]  c_FL_LAST    = (ARRAY_W > 1) ? FL_CW'(ARRAY_W - 2) : '0;

    // Bank 0 occupies entries 0..DEPTH-1, bank 1 entries DEPTH..2*DEPTH-1.
    function automatic logic [ADDR_W-1:0] f_addr(input logic bank, input logic [ROW_CW-1:0] row);
        return bank ? (ADDR_W'(DEPTH) + ADDR_W'(row)) : ADDR_W'(row);
    endfunction

    // ------------------------------------------------------------------
    // Tile storage (not reset)
    // ------------------------------------------------------------------
    logic [ROW_W-1:0] mem_q [2*DEPTH];

    // Loader side
    logic              wr_bank_q, wr_bank_d;
    logic [ROW_CW-1:0] wr_row_q,  wr_row_d;
    logic [1:0]        banks_full_q, banks_full_d;

    // Drain side
    drain_state_e      state_q;
    logic [ROW_CW-1:0] rd_row_q;
    logic              rd_bank_q;
    logic [FL_CW-1:0]  flush_cnt_q;
    logic              tile_done_q;
    logic [ROW_W-1:0]  stage_q;
    logic              stage_vld_q;

    logic              w_load_acc;
    logic              w_start;
    logic              w_last_row;
    logic              w_free;
    logic              w_stage_load;
    logic [ROW_CW-1:0] w_rd_row_nxt;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;

    assign w_load_acc   = buf_if.load_valid && !banks_full_q[wr_bank_q];
    assign w_start      = (state_q == ST_IDLE) && buf_if.drain_start && banks_full_q[rd_bank_q];
    assign w_last_row   = (rd_row_q == c_ROW_LAST);
    assign w_free       = (state_q == ST_DRAIN) && w_last_row;
    // The stage register is loaded one cycle ahead of the row it presents.
    assign w_stage_load = w_start || ((state_q == ST_DRAIN) && !w_last_row);

    always_comb begin
        w_rd_row_nxt = '0;
        if ((state_q == ST_DRAIN) && !w_last_row) begin
            w_rd_row_nxt = rd_row_q + ROW_CW'(1);
        end
    end

    assign w_rd_addr = f_addr(rd_bank_q, w_rd_row_nxt);
    assign w_wr_addr = f_addr(wr_bank_q, wr_row_q);

    always_ff @(posedge clk) begin
        if (w_load_acc) begin
            mem_q[w_wr_addr] <= buf_if.load_data;
        end
    end

    // ------------------------------------------------------------------
    // Loader pointers and full flags. Fill and free never target the same
    // bank because a bank being drained is full and refuses loads.
    // ------------------------------------------------------------------
    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_row_d     = wr_row_q;
        banks_full_d = banks_full_q;
        if (w_free) begin
            banks_full_d[rd_bank_q] = 1'b0;
        end
        if (w_load_acc) begin
            if (wr_row_q == c_ROW_LAST) begin
                banks_full_d[wr_bank_q] = 1'b1;
                wr_bank_d               = ~wr_bank_q;
                wr_row_d                = '0;
            end else begin
                wr_row_d = wr_row_q + ROW_CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q    <= 1'b0;
            wr_row_q     <= '0;
            banks_full_q <= 2'b00;
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_row_q     <= wr_row_d;
            banks_full_q <= banks_full_d;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM. tile_done is set one cycle early so it coincides with the
    // last valid element leaving the final column.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_row_q    <= '0;
            rd_bank_q   <= 1'b0;
            flush_cnt_q <= '0;
            tile_done_q <= 1'b0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
        end else begin
            tile_done_q <= 1'b0;
            stage_vld_q <= w_stage_load;
            if (w_stage_load) begin
                stage_q <= mem_q[w_rd_addr];
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_start) begin
                        state_q  <= ST_DRAIN;
                        rd_row_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_row) begin
                        rd_row_q  <= '0;
                        rd_bank_q <= ~rd_bank_q;
                        if (c_USE_FLUSH) begin
                            state_q     <= ST_FLUSH;
                            flush_cnt_q <= '0;
                            tile_done_q <= (ARRAY_W == 2);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        rd_row_q    <= rd_row_q + ROW_CW'(1);
                        tile_done_q <= !c_USE_FLUSH && (rd_row_q == c_ROW_PENULT);
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == c_FL_LAST) begin
                        state_q     <= ST_IDLE;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FL_CW'(1);
                        tile_done_q <= (ARRAY_W > 2) && ((flush_cnt_q + FL_CW'(1)) == c_FL_LAST);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-column delay lines; invalid columns present zero.
    // ------------------------------------------------------------------
    logic [ARRAY_W-1:0] w_out_valid;
    logic [ROW_W-1:0]   w_out_weight;

    generate
        for (genvar gi = 0; gi < ARRAY_W; gi++) begin : g_col
            localparam int c_STAGES = SKEW_EN ? gi : 0;
            logic [DATA_W-1:0] w_col_data;
            logic              w_col_vld;

            weight_skew_line #(
                .DATA_W (DATA_W),
                .STAGES (c_STAGES)
            ) u_skew_line (
                .clk     (clk),
                .rst     (rst),
                .data_i  (stage_q[gi*DATA_W +: DATA_W]),
                .valid_i (stage_vld_q),
                .data_o  (w_col_data),
                .valid_o (w_col_vld)
            );

            assign w_out_valid[gi]                 = w_col_vld;
            assign w_out_weight[gi*DATA_W +: DATA_W] = w_col_vld ? w_col_data : '0;
        end
    endgenerate

    assign buf_if.load_ready = !banks_full_q[wr_bank_q];
    assign buf_if.drain_busy = (state_q != ST_IDLE);
    assign buf_if.out_valid  = w_out_valid;
    assign buf_if.out_weight = w_out_weight;
    assign buf_if.tile_done  = tile_done_q;
    assign buf_if.banks_full = banks_full_q;

endmodule

`default_nettype wire

// File: tb/tb_weight_pingpong_skew_buffer.sv
// ============================================================================
//  Module  : tb_weight_pingpong_skew_buffer
//  Purpose : Drives a skewed (dut_a) and an aligned (dut_b) buffer with the
//            same stimulus and checks both against a schedule-based model.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_weight_pingpong_skew_buffer;

    localparam int ARRAY_W = 4;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int ROW_W   = ARRAY_W * DATA_W;
    localparam int NSLOT   = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lv  = 1'b0;
    logic             ds  = 1'b0;
    logic [ROW_W-1:0] ld  = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    weight_pingpong_skew_buffer_if #(.ARRAY_W(ARRAY_W), .DATA_W(DATA_W)) ifa ();
    weight_pingpong_skew_buffer_if #(.ARRAY_W(ARRAY_W), .DATA_W(DATA_W)) ifb ();

    assign ifa.load_valid  = lv;
    assign ifa.load_data   = ld;
    assign ifa.drain_start = ds;
    assign ifb.load_valid  = lv;
    assign ifb.load_data   = ld;
    assign ifb.drain_start = ds;

    weight_pingpong_skew_buffer #(
        .ARRAY_W(ARRAY_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SKEW_EN(1'b1)
    ) dut_a (.clk(clk), .rst(rst), .buf_if(ifa));

    weight_pingpong_skew_buffer #(
        .ARRAY_W(ARRAY_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SKEW_EN(1'b0)
    ) dut_b (.clk(clk), .rst(rst), .buf_if(ifb));

    // DUT outputs gathered per instance (0 = skewed, 1 = aligned)
    logic               d_ready [2];
    logic               d_busy  [2];
    logic [1:0]         d_full  [2];
    logic [ARRAY_W-1:0] d_ov    [2];
    logic [ROW_W-1:0]   d_ow    [2];
    logic               d_td    [2];

    assign d_ready[0] = ifa.load_ready;  assign d_ready[1] = ifb.load_ready;
    assign d_busy[0]  = ifa.drain_busy;  assign d_busy[1]  = ifb.drain_busy;
    assign d_full[0]  = ifa.banks_full;  assign d_full[1]  = ifb.banks_full;
    assign d_ov[0]    = ifa.out_valid;   assign d_ov[1]    = ifb.out_valid;
    assign d_ow[0]    = ifa.out_weight;  assign d_ow[1]    = ifb.out_weight;
    assign d_td[0]    = ifa.tile_done;   assign d_td[1]    = ifb.tile_done;

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: bank contents plus a timeline of expected outputs.
    // An accepted drain at cycle T writes the whole tile's future outputs
    // into the timeline: row r of column i appears at T+1+r(+i if skewed).
    // ------------------------------------------------------------------
    logic [ROW_W-1:0]   m_mem [2][2][DEPTH];
    logic [ARRAY_W-1:0] m_ev  [2][NSLOT];
    logic [ROW_W-1:0]   m_ew  [2][NSLOT];
    bit                 m_ed  [2][NSLOT];
    bit   [1:0]         m_full [2];
    int m_wb [2], m_wr [2], m_rb [2], m_fb [2], m_busy_until [2], m_free_at [2];
    int mcyc = 0;

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 2'b00; m_wb[d] = 0; m_wr[d] = 0; m_rb[d] = 0; m_fb[d] = 0;
            m_busy_until[d] = -1; m_free_at[d] = -1;
            for (int s = 0; s < NSLOT; s++) begin
                m_ev[d][s] = '0; m_ew[d][s] = '0; m_ed[d][s] = 1'b0;
            end
        end
    endfunction

    function automatic void model_update();
        for (int d = 0; d < 2; d++) begin
            int  skew  = (d == 0) ? 1 : 0;
            bit  acc_l = lv && !m_full[d][m_wb[d]];
            bit  acc_d = (mcyc > m_busy_until[d]) && ds && m_full[d][m_rb[d]];
            int  b     = m_rb[d];
            if (mcyc == m_free_at[d]) begin
                m_full[d][m_fb[d]] = 1'b0;
                m_rb[d] ^= 1;
            end
            if (acc_l) begin
                m_mem[d][m_wb[d]][m_wr[d]] = ld;
                if (m_wr[d] == DEPTH - 1) begin
                    m_full[d][m_wb[d]] = 1'b1;
                    m_wb[d] ^= 1;
                    m_wr[d] = 0;
                end else begin
                    m_wr[d]++;
                end
            end
            if (acc_d) begin
                for (int r = 0; r < DEPTH; r++) begin
                    for (int i = 0; i < ARRAY_W; i++) begin
                        int s = (mcyc + 1 + r + skew * i) % NSLOT;
                        m_ev[d][s][i] = 1'b1;
                        m_ew[d][s][i*DATA_W +: DATA_W] = m_mem[d][b][r][i*DATA_W +: DATA_W];
                    end
                end
                m_ed[d][(mcyc + DEPTH + skew * (ARRAY_W - 1)) % NSLOT] = 1'b1;
                m_busy_until[d] = mcyc + DEPTH + skew * (ARRAY_W - 1);
                m_free_at[d]    = mcyc + DEPTH;
                m_fb[d]         = b;
            end
        end
    endfunction

    task automatic compare_all();
        int s = mcyc % NSLOT;
        for (int d = 0; d < 2; d++) begin
            chk("load_ready", d, 64'(d_ready[d]), 64'(!m_full[d][m_wb[d]]));
            chk("drain_busy", d, 64'(d_busy[d]),  64'(mcyc <= m_busy_until[d]));
            chk("banks_full", d, 64'(d_full[d]),  64'(m_full[d]));
            chk("out_valid",  d, 64'(d_ov[d]),    64'(m_ev[d][s]));
            chk("out_weight", d, 64'(d_ow[d]),    64'(m_ew[d][s]));
            chk("tile_done",  d, 64'(d_td[d]),    64'(m_ed[d][s]));
            m_ev[d][s] = '0; m_ew[d][s] = '0; m_ed[d][s] = 1'b0;
        end
    endtask

    // Single compare process: checks at the falling edge, then advances the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
                compare_all();
            end else begin
                compare_all();
                model_update();
            end
            mcyc++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; lv = 1'b0; ds = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] col_b;
        bit         seen;
        do_reset();

        // Empty start: nothing to drain
        ds = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("empty_busy",  0, 64'(d_busy[0]), 64'(0));
            chk("empty_valid", 0, 64'(d_ov[0]),   64'(0));
        end
        ds = 1'b0;

        // Single tile: column c of row r = 16*r + c
        do_reset();
        for (int r = 0; r < DEPTH; r++) begin
            lv = 1'b1;
            for (int c = 0; c < ARRAY_W; c++) ld[c*DATA_W +: DATA_W] = 8'(16 * r + c);
            step();
        end
        lv = 1'b0;
        ds = 1'b1;                       // cycle T
        for (int k = 1; k <= 8; k++) begin
            step();
            ds = 1'b0;
            #1;
            col_b = ((k >= 3) && (k <= 6)) ? 8'(16 * (k - 3) + 2) : 8'h00;
            chk("lit_a_col2_vld", 0, 64'(d_ov[0][2]), 64'((k >= 3) && (k <= 6)));
            chk("lit_a_col2_dat", 0, 64'(d_ow[0][2*DATA_W +: DATA_W]), 64'(col_b));
            chk("lit_a_done",     0, 64'(d_td[0]), 64'(k == 7));
            col_b = (k <= 4) ? 8'(16 * (k - 1) + 3) : 8'h00;
            chk("lit_b_vld",      1, 64'(d_ov[1]), 64'((k <= 4) ? 4'hF : 4'h0));
            chk("lit_b_col3_dat", 1, 64'(d_ow[1][3*DATA_W +: DATA_W]), 64'(col_b));
            chk("lit_b_done",     1, 64'(d_td[1]), 64'(k == 4));
        end

        // Ping-pong: 8 back-to-back loads fill both banks
        do_reset();
        lv = 1'b1;
        for (int k = 0; k < 2 * DEPTH; k++) begin
            ld = ROW_W'($urandom());
            step();
        end
        #1;
        chk("pp_ready_low", 0, 64'(d_ready[0]), 64'(0));
        chk("pp_ready_low", 1, 64'(d_ready[1]), 64'(0));
        ds = 1'b1;                       // cycle T
        for (int k = 1; k <= DEPTH + 1; k++) begin
            step();
            ds = 1'b0;
            ld = ROW_W'($urandom());
            #1;
            if (k == DEPTH)     chk("pp_ready_held", 0, 64'(d_ready[0]), 64'(0));
            if (k == DEPTH + 1) chk("pp_ready_back", 0, 64'(d_ready[0]), 64'(1));
        end

        // Back-to-back drains with drain_start held and loads streaming
        ds = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ld = ROW_W'($urandom());
            step();
        end
        lv = 1'b0; ds = 1'b0;
        for (int k = 0; k < 10; k++) step();

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            lv = ($urandom_range(0, 9) < 7);
            ds = ($urandom_range(0, 9) < 3);
            ld = ROW_W'($urandom());
            step();
        end

        // Reset in the middle of a drain
        lv = 1'b1; ds = 1'b1; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            ld = ROW_W'($urandom());
            step();
            seen = d_busy[0];
        end
        chk("mid_drain_reached", 0, 64'(seen), 64'(1));
        step(); step();
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid",  d, 64'(d_ov[d]),    64'(0));
            chk("rst_out_weight", d, 64'(d_ow[d]),    64'(0));
            chk("rst_banks_full", d, 64'(d_full[d]),  64'(0));
            chk("rst_load_ready", d, 64'(d_ready[d]), 64'(1));
        end
        step();
        rst = 1'b0; lv = 1'b0; ds = 1'b0;

        // Short random run after reset
        for (int k = 0; k < 60; k++) begin
            lv = ($urandom_range(0, 9) < 6);
            ds = ($urandom_range(0, 9) < 4);
            ld = ROW_W'($urandom());
            step();
        end
        lv = 1'b0; ds = 1'b0;
        for (int k = 0; k < 12; k++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
